// File: rtl/i2c_master.sv
// I2C register-access master: single-byte register write, or register read
// using a repeated START. SCL is push-pull; SDA is open-drain (drives 0 or Z).
module i2c_master #(
  parameter logic [6:0] DEV_ADDR = 7'h55,
  parameter int         CLK_DIV  = 16
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] reg_idx,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       nack_err,
  output logic       SCL,
  inout  wire        SDA
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_ADDR_W, ST_ACK1, ST_IDX, ST_ACK2, ST_WDATA, ST_ACK3,
    ST_RSTART, ST_ADDR_R, ST_ACK4, ST_RDATA, ST_MNACK, ST_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ph_q, ph_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] div_q, div_d;
  logic        scl_q, scl_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        nack_q, nack_d;
  logic        ack_q, ack_d;
  logic [7:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  wd_q, wd_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  tx_byte;
  logic        tick;
  logic        sda_in;

  assign sda_in   = SDA;
  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign SCL      = scl_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_q;
  assign nack_err = nack_q;
  assign tick     = busy_q && (div_q == 16'(CLK_DIV - 1));

  // Byte currently being shifted out by the master
  always_comb begin
    tx_byte = 8'h00;
    case (state_q)
      ST_ADDR_W: tx_byte = {DEV_ADDR, 1'b0};
      ST_IDX:    tx_byte = idx_q;
      ST_WDATA:  tx_byte = wd_q;
      ST_ADDR_R: tx_byte = {DEV_ADDR, 1'b1};
      default:   tx_byte = 8'h00;
    endcase
  end

  // Next-state and bus-line control; every action happens on a quarter-bit tick
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    scl_d    = scl_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    nack_d   = nack_q;
    ack_d    = ack_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    idx_d    = idx_q;
    wd_d     = wd_q;
    sh_d     = sh_q;
    div_d    = (busy_q && !tick) ? div_q + 16'd1 : 16'd0;

    if (state_q == ST_IDLE) begin
      // A start coinciding with the done pulse is deliberately dropped
      if (start && !done_q) begin
        state_d  = ST_START;
        busy_d   = 1'b1;
        nack_d   = 1'b0;
        ack_d    = 1'b0;
        ph_d     = 2'd0;
        bit_d    = 3'd0;
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        rw_d     = rw;
        idx_d    = reg_idx;
        wd_d     = wr_data;
      end
    end else if (tick) begin
      ph_d = ph_q + 2'd1;
      case (ph_q)
        2'd0: begin
          case (state_q)
            ST_START:          sda_oe_d = 1'b1;
            ST_RSTART, ST_STOP: scl_d   = 1'b1;
            default: ;
          endcase
        end
        2'd1: begin
          case (state_q)
            ST_START:  scl_d    = 1'b0;
            ST_RSTART: sda_oe_d = 1'b1;
            ST_STOP:   sda_oe_d = 1'b0;
            default: begin
              // SCL rises: the sampling point of a bit
              scl_d = 1'b1;
              if (state_q inside {ST_ACK1, ST_ACK2, ST_ACK3, ST_ACK4}) begin
                ack_d = sda_in;
                if (sda_in) nack_d = 1'b1;
              end
              if (state_q == ST_RDATA) sh_d = {sh_q[6:0], sda_in};
            end
          endcase
        end
        2'd2: begin
          if (state_q == ST_RSTART) scl_d = 1'b0;
        end
        default: begin
          // Bit boundary: SCL falls and SDA takes the next bit value
          scl_d = 1'b0;
          case (state_q)
            ST_START: begin
              state_d = ST_ADDR_W; bit_d = 3'd7; sda_oe_d = ~DEV_ADDR[6];
            end
            ST_ADDR_W, ST_IDX, ST_WDATA, ST_ADDR_R: begin
              if (bit_q != 3'd0) begin
                bit_d    = bit_q - 3'd1;
                sda_oe_d = ~tx_byte[bit_q - 3'd1];
              end else begin
                sda_oe_d = 1'b0;
                case (state_q)
                  ST_ADDR_W: state_d = ST_ACK1;
                  ST_IDX:    state_d = ST_ACK2;
                  ST_WDATA:  state_d = ST_ACK3;
                  default:   state_d = ST_ACK4;
                endcase
              end
            end
            ST_ACK1: begin
              if (ack_q) begin state_d = ST_STOP; sda_oe_d = 1'b1; end
              else begin state_d = ST_IDX; bit_d = 3'd7; sda_oe_d = ~idx_q[7]; end
            end
            ST_ACK2: begin
              if (ack_q) begin state_d = ST_STOP; sda_oe_d = 1'b1; end
              else if (rw_q) begin state_d = ST_RSTART; sda_oe_d = 1'b0; end
              else begin state_d = ST_WDATA; bit_d = 3'd7; sda_oe_d = ~wd_q[7]; end
            end
            ST_RSTART: begin
              state_d = ST_ADDR_R; bit_d = 3'd7; sda_oe_d = ~DEV_ADDR[6];
            end
            ST_ACK4: begin
              if (ack_q) begin state_d = ST_STOP; sda_oe_d = 1'b1; end
              else begin state_d = ST_RDATA; bit_d = 3'd7; sda_oe_d = 1'b0; end
            end
            ST_RDATA: begin
              sda_oe_d = 1'b0;
              if (bit_q != 3'd0) bit_d = bit_q - 3'd1;
              else begin state_d = ST_MNACK; rd_d = sh_q; end
            end
            ST_ACK3, ST_MNACK: begin
              state_d = ST_STOP; sda_oe_d = 1'b1;
            end
            ST_STOP: begin
              state_d  = ST_IDLE;
              scl_d    = 1'b1;
              sda_oe_d = 1'b0;
              done_d   = 1'b1;
              busy_d   = 1'b0;
              ph_d     = 2'd0;
              bit_d    = 3'd0;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      endcase
    end
  end

  // Control state and bus lines; reset abandons any transfer without a STOP
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      ph_q     <= 2'd0;
      bit_q    <= 3'd0;
      div_q    <= 16'd0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
      ack_q    <= 1'b0;
      rd_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
      ack_q    <= ack_d;
      rd_q     <= rd_d;
    end
  end

  // Captured request and receive shifter; only meaningful while busy
  always_ff @(posedge clk) begin
    rw_q  <= rw_d;
    idx_q <= idx_d;
    wd_q  <= wd_d;
    sh_q  <= sh_d;
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: behavioural register slave, bus byte monitor with
// an expected-byte queue, START/STOP counters and done-pulse counter.
module tb_i2c_master;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] reg_idx = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       busy, done, nack_err, SCL;
  logic [7:0] rd_data;
  wire        SDA;
  logic       sl_drv = 1'b0;

  pullup (SDA);
  assign SDA = sl_drv ? 1'b0 : 1'bz;

  i2c_master #(.DEV_ADDR(7'h55), .CLK_DIV(4)) dut (
    .clk(clk), .RST(RST), .start(start), .rw(rw), .reg_idx(reg_idx),
    .wr_data(wr_data), .busy(busy), .done(done), .rd_data(rd_data),
    .nack_err(nack_err), .SCL(SCL), .SDA(SDA)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] sl_regs [256];
  logic [6:0] sl_addr = 7'h55;
  int n_start = 0, n_stop = 0, n_done = 0, mon_bytes = 0, mcnt = 0;
  logic [8:0] msh = 9'h0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  int sl_st = 0, sl_cnt = 0, sl_bnum = 0;
  logic [7:0] sl_sh = 8'h0, sl_ptr = 8'h0, sl_tx = 8'h0;
  logic sl_rd = 1'b0;

  // Bus monitor, byte scoreboard and register slave, all sampled on negedge
  always @(negedge clk) begin : bus_proc
    logic sda;
    logic [8:0] e;
    sda = (SDA === 1'b0) ? 1'b0 : 1'b1;
    if (done) n_done++;
    if (prev_scl && SCL && (sda != prev_sda)) begin
      if (!sda) begin
        n_start++; mcnt = 0; sl_st = 1; sl_cnt = 0; sl_bnum = 0; sl_drv = 1'b0;
      end else begin
        n_stop++; mcnt = 0; sl_st = 0; sl_drv = 1'b0;
      end
    end else if (!prev_scl && SCL) begin
      msh = {msh[7:0], sda};
      mcnt++;
      if (mcnt == 9) begin
        mcnt = 0;
        mon_bytes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_byte: got %h ack %b, nothing expected", msh[8:1], msh[0]);
        end else begin
          e = exp_q.pop_front();
          if (msh !== e) begin
            errors++;
            $display("FAIL bus_byte: got %h ack %b, expected %h ack %b",
                     msh[8:1], msh[0], e[8:1], e[0]);
          end
        end
      end
      if (sl_st == 1) begin sl_sh = {sl_sh[6:0], sda}; sl_cnt++; end
    end else if (prev_scl && !SCL) begin
      case (sl_st)
        1: if (sl_cnt == 8) begin
             sl_cnt = 0;
             if (sl_bnum == 0) begin
               if (sl_sh[7:1] == sl_addr) begin sl_drv = 1'b1; sl_rd = sl_sh[0]; sl_st = 2; end
               else sl_st = 0;
             end else if (sl_bnum == 1) begin
               sl_ptr = sl_sh; sl_drv = 1'b1; sl_st = 2;
             end else begin
               sl_regs[sl_ptr] = sl_sh; sl_drv = 1'b1; sl_st = 2;
             end
             sl_bnum++;
           end
        2: begin
             sl_drv = 1'b0;
             if (sl_rd) begin
               sl_tx = sl_regs[sl_ptr]; sl_drv = ~sl_tx[7]; sl_cnt = 1; sl_st = 3;
             end else begin
               sl_st = 1; sl_cnt = 0;
             end
           end
        3: if (sl_cnt == 8) begin sl_drv = 1'b0; sl_st = 0; end
           else begin sl_drv = ~sl_tx[7 - sl_cnt]; sl_cnt++; end
        default: ;
      endcase
    end
    prev_scl = SCL;
    prev_sda = sda;
  end

  // mode 0: plain, 1: extra start 10 cycles in, 2: start during done cycle
  task automatic run_txn(input logic r, input logic [7:0] idx, input logic [7:0] wd, input int mode);
    int n0;
    bit got;
    n0 = n_done;
    rw = r; reg_idx = idx; wr_data = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise: busy=%b expected 1", busy); end
    checks++;
    if (nack_err !== 1'b0) begin errors++; $display("FAIL nack_clear: nack_err=%b expected 0", nack_err); end
    rw = ~r; reg_idx = 8'hFF; wr_data = 8'h00;
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done === 1'b1) begin got = 1'b1; break; end
      start = (mode == 1 && i == 9) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++; $display("FAIL done_timeout: done=%b expected 1 within 4000 cycles", done);
    end else begin
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: busy=%b expected 0 with done", busy); end
      if (mode == 2) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL start_at_done: busy=%b expected 0", busy); end
      @(negedge clk);
      checks++;
      if (n_done - n0 != 1) begin errors++; $display("FAIL done_count: got %0d expected 1", n_done - n0); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_after: busy=%b expected 0", busy); end
    end
  endtask

  task automatic check_bus(input string name, input int s0, input int p0, input int es, input int ep);
    checks++;
    if (n_start - s0 != es) begin errors++; $display("FAIL %s_starts: got %0d expected %0d", name, n_start - s0, es); end
    checks++;
    if (n_stop - p0 != ep) begin errors++; $display("FAIL %s_stops: got %0d expected %0d", name, n_stop - p0, ep); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL %s_leftover: %0d bytes not seen, expected 0", name, exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (SCL !== 1'b1) begin errors++; $display("FAIL rst_scl: got %b expected 1", SCL); end
    checks++; if (SDA !== 1'b1) begin errors++; $display("FAIL rst_sda: got %b expected 1 (released)", SDA); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (nack_err !== 1'b0) begin errors++; $display("FAIL rst_nack: got %b expected 0", nack_err); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data: got %h expected 00", rd_data); end
    RST = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    int s0 = n_start, p0 = n_stop;
    exp_q.push_back({8'hAA, 1'b0}); exp_q.push_back({8'h03, 1'b0}); exp_q.push_back({8'h57, 1'b0});
    run_txn(1'b0, 8'h03, 8'h57, 0);
    checks++; if (sl_regs[3] !== 8'h57) begin errors++; $display("FAIL wr_reg03: got %h expected 57", sl_regs[3]); end
    checks++; if (nack_err !== 1'b0) begin errors++; $display("FAIL wr_nack: got %b expected 0", nack_err); end
    check_bus("write", s0, p0, 1, 1);
  endtask

  task automatic test_read();
    int s0 = n_start, p0 = n_stop;
    exp_q.push_back({8'hAA, 1'b0}); exp_q.push_back({8'h03, 1'b0});
    exp_q.push_back({8'hAB, 1'b0}); exp_q.push_back({8'h57, 1'b1});
    run_txn(1'b1, 8'h03, 8'h11, 0);
    checks++; if (rd_data !== 8'h57) begin errors++; $display("FAIL rd_data: got %h expected 57", rd_data); end
    checks++; if (nack_err !== 1'b0) begin errors++; $display("FAIL rd_nack: got %b expected 0", nack_err); end
    check_bus("read", s0, p0, 2, 1);
  endtask

  task automatic test_addr_nack();
    int s0 = n_start, p0 = n_stop;
    sl_addr = 7'h22;
    exp_q.push_back({8'hAA, 1'b1});
    run_txn(1'b1, 8'h03, 8'h99, 0);
    checks++; if (nack_err !== 1'b1) begin errors++; $display("FAIL nack_set: got %b expected 1", nack_err); end
    checks++; if (rd_data !== 8'h57) begin errors++; $display("FAIL nack_rd_keep: got %h expected 57", rd_data); end
    repeat (5) @(negedge clk);
    checks++; if (nack_err !== 1'b1) begin errors++; $display("FAIL nack_hold: got %b expected 1", nack_err); end
    check_bus("nack", s0, p0, 1, 1);
    sl_addr = 7'h55;
  endtask

  task automatic test_back_to_back();
    int s0 = n_start, p0 = n_stop;
    exp_q.push_back({8'hAA, 1'b0}); exp_q.push_back({8'h03, 1'b0}); exp_q.push_back({8'h57, 1'b0});
    run_txn(1'b0, 8'h03, 8'h57, 1);
    check_bus("busy_start", s0, p0, 1, 1);
    s0 = n_start; p0 = n_stop;
    exp_q.push_back({8'hAA, 1'b0}); exp_q.push_back({8'h04, 1'b0}); exp_q.push_back({8'h3C, 1'b0});
    run_txn(1'b0, 8'h04, 8'h3C, 2);
    checks++; if (sl_regs[4] !== 8'h3C) begin errors++; $display("FAIL wr_reg04: got %h expected 3C", sl_regs[4]); end
    check_bus("done_start", s0, p0, 1, 1);
  endtask

  task automatic test_reset_mid();
    int b0 = mon_bytes;
    bit got = 1'b0;
    exp_q.push_back({8'hAA, 1'b0});
    rw = 1'b0; reg_idx = 8'h01; wr_data = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (mon_bytes == b0 + 1 && mcnt >= 3) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!got) begin errors++; $display("FAIL mid_wait: IDX byte not reached, bytes=%0d", mon_bytes - b0); end
    #2 RST = 1'b0;
    #1;
    checks++; if (SCL !== 1'b1) begin errors++; $display("FAIL mid_scl: got %b expected 1", SCL); end
    checks++; if (SDA !== 1'b1) begin errors++; $display("FAIL mid_sda: got %b expected 1 (released)", SDA); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mid_rd_data: got %h expected 00", rd_data); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_leftover: %0d expected 0", exp_q.size()); exp_q.delete(); end
    repeat (2) @(negedge clk);
    RST = 1'b1;
    exp_q.push_back({8'hAA, 1'b0}); exp_q.push_back({8'h01, 1'b0}); exp_q.push_back({8'hA5, 1'b0});
    run_txn(1'b0, 8'h01, 8'hA5, 0);
    checks++; if (sl_regs[1] !== 8'hA5) begin errors++; $display("FAIL wr_reg01: got %h expected A5", sl_regs[1]); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL post_rst_leftover: %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sl_regs[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
